// File: rtl/add_round_key_col_if.sv
// Column-in / state-out handshake bundle for the column-serial AddRoundKey stage.
interface add_round_key_col_if;
  logic         key_load;
  logic [127:0] key_in;
  logic         col_valid;
  logic         col_ready;
  logic [31:0]  col_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic [3:0]   round_idx;
  logic         last_round;

  modport master (
    output key_load, key_in, col_valid, col_data, out_ready,
    input  col_ready, out_valid, state_out, round_idx, last_round
  );

  modport slave (
    input  key_load, key_in, col_valid, col_data, out_ready,
    output col_ready, out_valid, state_out, round_idx, last_round
  );
endinterface

// File: rtl/add_round_key_col.sv
// Column-serial AddRoundKey: XORs each mixColumns column with its round-key word,
// assembles four columns into a 128-bit state and tracks the round index.
module add_round_key_col #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  add_round_key_col_if.slave bus
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t       r_state, w_state_nxt;
  logic [1:0]   r_col_cnt, w_cnt_nxt;
  logic [127:0] r_key;
  logic         r_key_vld;
  logic [31:0]  r_slot [4];
  logic [3:0]   r_round_idx;

  logic         w_col_ready;
  logic         w_accept;
  logic         w_fire;
  logic [31:0]  w_key_word;

  // In HOLD a column may only enter when the held state leaves the same cycle.
  assign w_col_ready = r_key_vld && ((r_state == COLLECT) || bus.out_ready);
  assign w_accept    = bus.col_valid && w_col_ready;
  assign w_fire      = (r_state == HOLD) && bus.out_ready;

  always_comb begin
    w_key_word = r_key[127:96];
    case (r_col_cnt)
      2'd0: w_key_word = r_key[127:96];
      2'd1: w_key_word = r_key[95:64];
      2'd2: w_key_word = r_key[63:32];
      2'd3: w_key_word = r_key[31:0];
      default: w_key_word = r_key[127:96];
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_col_cnt;
    case (r_state)
      COLLECT: begin
        if (w_accept) begin
          w_cnt_nxt = r_col_cnt + 2'd1;
          if (r_col_cnt == 2'd3) w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        // col_cnt is 0 on entering HOLD, so a pass-through column lands in slot0.
        if (w_fire) begin
          w_state_nxt = COLLECT;
          w_cnt_nxt   = w_accept ? 2'd1 : 2'd0;
        end
      end
      default: begin
        w_state_nxt = COLLECT;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= COLLECT;
      r_col_cnt <= 2'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_col_cnt <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_key     <= '0;
      r_key_vld <= 1'b0;
    end else if (bus.key_load) begin
      r_key     <= bus.key_in;
      r_key_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_slot[i] <= '0;
    end else if (w_accept) begin
      r_slot[r_col_cnt] <= bus.col_data ^ w_key_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_round_idx <= '0;
    end else if (w_fire) begin
      r_round_idx <= (r_round_idx == 4'(NUM_ROUNDS - 1)) ? 4'd0 : r_round_idx + 4'd1;
    end
  end

  assign bus.col_ready  = w_col_ready;
  assign bus.out_valid  = (r_state == HOLD);
  assign bus.state_out  = {r_slot[0], r_slot[1], r_slot[2], r_slot[3]};
  assign bus.round_idx  = r_round_idx;
  assign bus.last_round = (r_state == HOLD) && (r_round_idx == 4'(NUM_ROUNDS - 1));

endmodule

// File: tb/tb_add_round_key_col.sv
// Randomized scoreboard bench for add_round_key_col: driver models accepted columns,
// monitor pops expected states on each output handshake.
module tb_add_round_key_col;
  localparam int NR = 10;

  typedef struct {
    logic [127:0] st;
    logic [3:0]   rnd;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  add_round_key_col_if ifc();

  add_round_key_col #(.NUM_ROUNDS(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  exp_t q[$];

  logic [127:0] mkey;
  logic [31:0]  mcols [4];
  int           mn;
  int           mround;
  int           n_acc;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    mkey = '0; mn = 0; mround = 0;
  endtask

  task automatic model_accept(input logic [31:0] d);
    exp_t e;
    mcols[mn] = d ^ mkey[127 - 32*mn -: 32];
    mn++;
    n_acc++;
    if (mn == 4) begin
      e.st   = {mcols[0], mcols[1], mcols[2], mcols[3]};
      e.rnd  = 4'(mround);
      e.last = (mround == NR - 1);
      q.push_back(e);
      mround = (mround + 1) % NR;
      mn = 0;
    end
  endtask

  // Caller sets inputs right after a negedge; this records the cycle's effect and advances.
  task automatic step();
    #1;
    if (!rst_n) model_clear();
    else begin
      if (ifc.col_valid && ifc.col_ready) model_accept(ifc.col_data);
      if (ifc.key_load) mkey = ifc.key_in;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic cv, input logic [31:0] cd, input logic ordy,
                       input logic kl, input logic [127:0] kin);
    ifc.col_valid = cv; ifc.col_data = cd; ifc.out_ready = ordy;
    ifc.key_load = kl; ifc.key_in = kin;
  endtask

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && ifc.out_valid && ifc.out_ready) begin
      if (q.size() == 0) begin
        checks++; fails++;
        $display("FAIL unexpected_out: got state %h expected no output", ifc.state_out);
      end else begin
        e = q.pop_front();
        chk("state_out", ifc.state_out, e.st);
        chk("round_idx", 128'(ifc.round_idx), 128'(e.rnd));
        chk("last_round", 128'(ifc.last_round), 128'(e.last));
      end
    end
  end

  localparam logic [127:0] FIPS_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;

  initial begin
    logic [31:0]  fcols [4];
    logic [127:0] held;
    int           a0;
    fcols[0] = 32'h046681e5; fcols[1] = 32'he0cb199a;
    fcols[2] = 32'h48f8d37a; fcols[3] = 32'h2806264c;
    n_acc = 0;
    model_clear();
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, '0);
    @(negedge clk);
    step(); step();
    chk("rst_out_valid", 128'(ifc.out_valid), 128'd0);
    chk("rst_state_out", ifc.state_out, 128'd0);
    chk("rst_round_idx", 128'(ifc.round_idx), 128'd0);
    rst_n = 1'b1;

    // No key loaded: columns must be refused
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, $urandom, 1'b1, 1'b0, '0);
      #1;
      chk("nokey_col_ready", 128'(ifc.col_ready), 128'd0);
      chk("nokey_out_valid", 128'(ifc.out_valid), 128'd0);
      step();
    end

    // FIPS-197 round 1 vector, downstream stalled afterwards
    drive(1'b0, '0, 1'b0, 1'b1, FIPS_KEY);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fcols[i], 1'b0, 1'b0, '0);
      step();
    end
    chk("fips_latency_valid", 128'(ifc.out_valid), 128'd1);
    chk("fips_state", ifc.state_out, FIPS_OUT);
    chk("fips_round", 128'(ifc.round_idx), 128'd0);

    // Backpressure: state held, columns refused
    held = ifc.state_out;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, $urandom, 1'b0, 1'b0, '0);
      #1;
      chk("bp_col_ready", 128'(ifc.col_ready), 128'd0);
      chk("bp_state_stable", ifc.state_out, held);
      step();
    end
    drive(1'b1, $urandom, 1'b1, 1'b0, '0);
    #1;
    chk("passthru_col_ready", 128'(ifc.col_ready), 128'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, 1'b0, 1'b0, '0);
      step();
    end
    chk("bp_next_round", 128'(ifc.round_idx), 128'd1);

    // Back-to-back: 12 columns in 12 cycles
    a0 = n_acc;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, $urandom, 1'b1, 1'b0, '0);
      step();
    end
    chk("b2b_accepts", 128'(n_acc - a0), 128'd12);

    // Random traffic: many blocks so round_idx wraps past NUM_ROUNDS
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0, {$urandom, $urandom, $urandom, $urandom});
      step();
    end
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    step(); step();
    chk("drain_queue", 128'(q.size()), 128'd0);

    // Reset mid-block after two columns
    drive(1'b0, '0, 1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom});
    step();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, $urandom, 1'b1, 1'b0, '0);
      step();
    end
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    step();
    rst_n = 1'b1;
    drive(1'b1, $urandom, 1'b1, 1'b0, '0);
    #1;
    chk("rst_mid_col_ready", 128'(ifc.col_ready), 128'd0);
    chk("rst_mid_round", 128'(ifc.round_idx), 128'd0);
    step();
    drive(1'b0, '0, 1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom});
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, $urandom, 1'b0, 1'b0, '0);
      step();
    end
    chk("rst_reload_valid", 128'(ifc.out_valid), 128'd1);
    drive(1'b0, '0, 1'b1, 1'b0, '0);
    step(); step();
    chk("final_drain", 128'(q.size()), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
